// File: rtl/cdc_sync_pkg.sv
// Shared CDC definitions: handshake FSM state encoding and synchronizer depth floor.
package cdc_sync_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } hs_state_e;

   localparam int CDC_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/pulse_handshake_tx_if.sv
// Signal bundle between the pulse handshake source and its environment.
interface pulse_handshake_tx_if #(
   parameter int PEND_W = 3
);
   import cdc_sync_pkg::*;

   // Four-phase handshake: o_req_level rises to offer one event, the receiver raises
   // i_ack_async once it has seen it, req then drops, and the event is complete only
   // after ack has also returned low. A new req never rises while ack is still high.
   logic              i_pulse;
   logic              i_ack_async;
   logic              o_req_level;
   logic              o_busy;
   logic [PEND_W-1:0] o_pending;
   logic              o_done;
   logic              o_overflow;
   logic              o_timeout;
   hs_state_e         dbg_state;

   modport master (
      input  i_pulse,
      input  i_ack_async,
      output o_req_level,
      output o_busy,
      output o_pending,
      output o_done,
      output o_overflow,
      output o_timeout,
      output dbg_state
   );

   modport slave (
      output i_pulse,
      output i_ack_async,
      input  o_req_level,
      input  o_busy,
      input  o_pending,
      input  o_done,
      input  o_overflow,
      input  o_timeout,
      input  dbg_state
   );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop level synchronizer for a single asynchronous bit, reset to 0.
module bit_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[STAGES-2:0], d};
      end
   end

   assign q = sync[STAGES-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// Source side of a pulse-over-four-phase-handshake CDC path with pending-event counting.
// Optional handshake abort on a stuck receiver: define PULSE_TX_TIMEOUT_EN.
module pulse_handshake_tx
   import cdc_sync_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int PEND_W      = 3,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   pulse_handshake_tx_if.master  bus
);

   localparam logic [1:0]        ST_IDLE  = IDLE;
   localparam logic [1:0]        ST_REQ   = REQ;
   localparam logic [1:0]        ST_DROP  = DROP;
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_sync_stages
      $error("pulse_handshake_tx: SYNC_STAGES below CDC_MIN_SYNC_STAGES");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("pulse_handshake_tx: TIMEOUT_CYC must be at least 1");
   end

   logic              ack_sync;
   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [PEND_W-1:0] pending;
   logic [PEND_W-1:0] pending_nxt;
   logic              launch;
   logic              to_hit;
   logic              done_nxt;
   logic              ovf_nxt;
   logic              req_q;
   logic              done_q;
   logic              ovf_q;

   bit_synchronizer #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .d     (bus.i_ack_async),
      .q     (ack_sync)
   );

   // A high ack_sync in IDLE means the receiver has not finished the last phase yet.
   assign launch = (state == ST_IDLE) && !ack_sync && ((pending != '0) || bus.i_pulse);

`ifdef PULSE_TX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0] to_cnt;
   logic            to_q;

   assign to_hit = (state != ST_IDLE) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         to_cnt <= '0;
         to_q   <= 1'b0;
      end else begin
         to_q <= to_hit;
         if ((state == ST_IDLE) || (state_nxt != state)) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + TO_W'(1);
         end
      end
   end

   assign bus.o_timeout = to_q;
`else
   assign to_hit        = 1'b0;
   assign bus.o_timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE: if (launch) state_nxt = ST_REQ;
         ST_REQ:  if (ack_sync) state_nxt = ST_DROP;
         ST_DROP: begin
            if (!ack_sync) begin
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // An abort overrides whatever the handshake was about to do.
      if (to_hit) begin
         state_nxt = ST_IDLE;
         done_nxt  = 1'b0;
      end
   end

   always_comb begin
      pending_nxt = pending;
      ovf_nxt     = 1'b0;
      if (to_hit) begin
         pending_nxt = '0;
      end else if (bus.i_pulse && !launch) begin
         if (pending == PEND_MAX) begin
            ovf_nxt = 1'b1;
         end else begin
            pending_nxt = pending + PEND_W'(1);
         end
      end else if (!bus.i_pulse && launch) begin
         pending_nxt = pending - PEND_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= ST_IDLE;
         pending <= '0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
         req_q   <= (state_nxt == ST_REQ);
         done_q  <= done_nxt;
         ovf_q   <= ovf_nxt;
      end
   end

   assign bus.o_req_level = req_q;
   assign bus.o_busy      = (state != ST_IDLE) || (pending != '0);
   assign bus.o_pending   = pending;
   assign bus.o_done      = done_q;
   assign bus.o_overflow  = ovf_q;
   assign bus.dbg_state   = hs_state_e'(state);

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Directed bench for pulse_handshake_tx with a req-delayed-by-3-edges receiver model.
module tb_pulse_handshake_tx;

   localparam int PW = 2;

   logic       clk;
   logic       rst_n;
   logic       rx_en;
   logic       ack_force;
   logic [2:0] rx_sh;
   int         n_chk;
   int         n_bad;
   int         done_cnt;

   pulse_handshake_tx_if #(.PEND_W(PW)) bus ();

   pulse_handshake_tx #(
      .SYNC_STAGES (2),
      .PEND_W      (PW),
      .TIMEOUT_CYC (64)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired n_chk=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   // receiver: ack is req delayed by three rising edges
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_sh <= 3'b000;
      else        rx_sh <= {rx_sh[1:0], bus.o_req_level};
   end
   assign bus.i_ack_async = rx_en ? rx_sh[2] : ack_force;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (bus.o_done) done_cnt++;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (bus.o_busy && n < budget) begin
         step();
         n++;
      end
      chk(tag, bus.o_busy, 0);
      repeat (4) step();
   endtask

   // req high for handshakes launched every 13 cycles starting in cycle 1
   function automatic logic exp_req(input int rel, input int n_hs);
      for (int k = 0; k < n_hs; k++) begin
         if (rel >= 1 + 13 * k && rel <= 6 + 13 * k) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic exp_done(input int rel, input int n_hs);
      for (int k = 1; k <= n_hs; k++) begin
         if (rel == 13 * k) return 1'b1;
      end
      return 1'b0;
   endfunction

   initial begin
      n_chk     = 0;
      n_bad     = 0;
      done_cnt  = 0;
      rst_n     = 1'b0;
      rx_en     = 1'b1;
      ack_force = 1'b0;
      bus.i_pulse = 1'b0;

      // reset state
      #2;
      chk("rst_req", bus.o_req_level, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_pend", bus.o_pending, 0);
      chk("rst_done", bus.o_done, 0);
      chk("rst_ovf", bus.o_overflow, 0);
      chk("rst_to", bus.o_timeout, 0);
      chk("rst_state", bus.dbg_state, 0);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (3) step();

      // single pulse
      for (int rel = 0; rel < 16; rel++) begin
         bus.i_pulse = (rel == 0);
         chk($sformatf("t1_req_%0d", rel), bus.o_req_level, exp_req(rel, 1));
         chk($sformatf("t1_done_%0d", rel), bus.o_done, exp_done(rel, 1));
         chk($sformatf("t1_pend_%0d", rel), bus.o_pending, 0);
         chk($sformatf("t1_to_%0d", rel), bus.o_timeout, 0);
         step();
      end
      bus.i_pulse = 1'b0;
      wait_idle("t1_idle", 50);

      // three back-to-back pulses
      done_cnt = 0;
      for (int rel = 0; rel < 42; rel++) begin
         bus.i_pulse = (rel <= 2);
         chk($sformatf("t2_req_%0d", rel), bus.o_req_level, exp_req(rel, 3));
         chk($sformatf("t2_done_%0d", rel), bus.o_done, exp_done(rel, 3));
         chk($sformatf("t2_pend_%0d", rel), bus.o_pending,
             (rel < 2) ? 0 : (rel == 2) ? 1 : (rel <= 13) ? 2 : (rel <= 26) ? 1 : 0);
         step();
      end
      bus.i_pulse = 1'b0;
      wait_idle("t2_idle", 50);
      chk("t2_ndone", done_cnt, 3);

      // saturation with ack stuck low
      done_cnt = 0;
      rx_en    = 1'b0;
      for (int rel = 0; rel < 8; rel++) begin
         bus.i_pulse = (rel <= 4);
         chk($sformatf("t3_req_%0d", rel), bus.o_req_level, (rel >= 1));
         chk($sformatf("t3_ovf_%0d", rel), bus.o_overflow, (rel == 5));
         chk($sformatf("t3_pend_%0d", rel), bus.o_pending,
             (rel < 2) ? 0 : (rel == 2) ? 1 : (rel == 3) ? 2 : 3);
         step();
      end
      bus.i_pulse = 1'b0;
      rx_en = 1'b1;
      wait_idle("t3_idle", 200);
      chk("t3_ndone", done_cnt, 4);

      // pulse on the launch cycle of a pending event
      done_cnt = 0;
      for (int rel = 0; rel < 30; rel++) begin
         bus.i_pulse = (rel == 0) || (rel == 1) || (rel == 13);
         chk($sformatf("t4_req_%0d", rel), bus.o_req_level, exp_req(rel, 3));
         chk($sformatf("t4_pend_%0d", rel), bus.o_pending,
             (rel < 2) ? 0 : (rel <= 26) ? 1 : 0);
         step();
      end
      bus.i_pulse = 1'b0;
      wait_idle("t4_idle", 100);
      chk("t4_ndone", done_cnt, 3);

      // reset mid-DROP, then launch gated by a high ack_sync
      done_cnt = 0;
      for (int rel = 0; rel < 8; rel++) begin
         bus.i_pulse = (rel == 0);
         chk($sformatf("t5_req_%0d", rel), bus.o_req_level, exp_req(rel, 1));
         step();
      end
      bus.i_pulse = 1'b0;
      chk("t5_state_drop", bus.dbg_state, 2);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_req", bus.o_req_level, 0);
      chk("t5_rst_busy", bus.o_busy, 0);
      chk("t5_rst_pend", bus.o_pending, 0);
      chk("t5_rst_done", bus.o_done, 0);
      chk("t5_rst_ovf", bus.o_overflow, 0);
      chk("t5_rst_to", bus.o_timeout, 0);
      chk("t5_rst_state", bus.dbg_state, 0);
      repeat (3) step();
      rst_n     = 1'b1;
      rx_en     = 1'b0;
      ack_force = 1'b1;
      repeat (4) step();
      bus.i_pulse = 1'b1;
      step();
      bus.i_pulse = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t5_blk_req_%0d", k), bus.o_req_level, 0);
         chk($sformatf("t5_blk_pend_%0d", k), bus.o_pending, 1);
         step();
      end
      ack_force = 1'b0;
      chk("t5_rel_req0", bus.o_req_level, 0);
      step();
      chk("t5_rel_req1", bus.o_req_level, 0);
      step();
      chk("t5_rel_req2", bus.o_req_level, 0);
      step();
      chk("t5_rel_req3", bus.o_req_level, 1);
      chk("t5_rel_pend3", bus.o_pending, 0);
      rx_en = 1'b1;
      wait_idle("t5_idle", 50);
      chk("t5_ndone", done_cnt, 1);

`ifdef PULSE_TX_TIMEOUT_EN
      // stuck receiver aborted by the timeout
      done_cnt = 0;
      rx_en    = 1'b0;
      for (int rel = 0; rel < 68; rel++) begin
         bus.i_pulse = (rel <= 1);
         chk($sformatf("t6_req_%0d", rel), bus.o_req_level, (rel >= 1 && rel <= 64));
         chk($sformatf("t6_to_%0d", rel), bus.o_timeout, (rel == 65));
         chk($sformatf("t6_pend_%0d", rel), bus.o_pending, (rel >= 2 && rel <= 64));
         step();
      end
      bus.i_pulse = 1'b0;
      chk("t6_busy", bus.o_busy, 0);
      chk("t6_ndone", done_cnt, 0);
      rx_en = 1'b1;
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/pulse_handshake_tx.md
# pulse_handshake_tx

Source-side end of the cross-domain event transfer path. It accepts single-cycle event pulses in the `i_clk` domain and carries each one across to the receiving domain with a four-phase req/ack level handshake. The receiver edge-detects `o_req_level` with its level-to-pulse synchronizer and returns its synchronized req level as ack. Events arriving while a handshake is in flight are counted and issued back-to-back, so no event is lost below the saturation depth.

## Interface
- `SYNC_STAGES`, default 2: flops in the ack synchronizer, legal values 2 or more.
- `PEND_W`, default 3: width of the pending-event counter; maximum count is 2^PEND_W-1.
- `TIMEOUT_CYC`, default 64: handshake timeout in cycles; used only with `PULSE_TX_TIMEOUT_EN`.
- `i_clk` in 1: source-domain clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_pulse` in 1: event strobe, one event per high cycle.
- `i_ack_async` in 1: ack level from the receiver domain, asynchronous to `i_clk`.
- `o_req_level` in/out: out 1, registered request level to the receiver.
- `o_busy` out 1: high when the FSM is not IDLE or when pending is nonzero.
- `o_pending` out PEND_W: count of events not yet launched.
- `o_done` out 1: one-cycle strobe when a handshake completes.
- `o_overflow` out 1: one-cycle strobe when an event is dropped at saturation.
- `o_timeout` out 1: one-cycle strobe when a handshake is aborted; constant 0 without the macro.

## Operation
- `ack_sync` is `i_ack_async` passed through SYNC_STAGES flops, all reset to 0.
- FSM states: IDLE, REQ, DROP.
  - IDLE → REQ when `launch` is true. `launch` = IDLE && `ack_sync`==0 && (`o_pending`!=0 || `i_pulse`).
  - REQ → DROP when `ack_sync`==1.
  - DROP → IDLE when `ack_sync`==0; `o_done`=1 in the cycle IDLE is entered.
- `o_req_level` is 1 only while the FSM is in REQ. It is driven from a flop, never combinationally.
- Pending counter: next = pending + `i_pulse` − `launch`.
  - A pulse and a launch in the same cycle leave the count unchanged.
  - A pulse in IDLE with pending 0 launches directly and never increments the counter.
- Saturation: when pending = max, `i_pulse`=1 and no launch occurs, the count holds and `o_overflow`=1 in the next cycle.
- `ack_sync` changes in unexpected states are ignored: a high in IDLE blocks launch, a low in REQ waits.
- Reset (asynchronous, legal mid-handshake):
  - state IDLE, all synchronizer flops 0, pending 0.
  - `o_req_level`, `o_done`, `o_overflow`, `o_timeout` all 0.

## Timing
- Cycle k means the interval after rising edge k. `i_pulse` is high in cycle 0.
- Launch latency: `o_req_level` rises in cycle 1.
- Ack path: an `i_ack_async` change first shows in `ack_sync` SYNC_STAGES cycles later; the FSM reacts at the following edge.
- Worked example: SYNC_STAGES=2, receiver returns ack = req delayed 3 edges.
  - Ack high in cycle 4; `ack_sync` high in cycle 6; req falls in cycle 7.
  - Ack low in cycle 10; `ack_sync` low in cycle 12; IDLE entered and `o_done`=1 in cycle 13.
  - A pending event launches in cycle 14, giving a 13-cycle issue period.
- Minimum IDLE dwell between handshakes is one cycle.
- All strobe outputs are registered and last exactly one cycle.

## Configuration
- Macro `PULSE_TX_TIMEOUT_EN`.
- Defined:
  - A counter runs while the FSM is in REQ or DROP and clears on each state transition.
  - On reaching TIMEOUT_CYC consecutive cycles in one state, the FSM forces IDLE and `o_req_level`=0.
  - pending clears to 0 and `o_timeout`=1 for one cycle; `o_done` stays 0.
  - The next launch is still gated by `ack_sync`==0.
- Undefined: the counter logic is absent, `o_timeout` is tied to 0, and a handshake waits indefinitely.

## Structure
- Shared package `cdc_sync_pkg`:
  - state enum `hs_state_e` (IDLE, REQ, DROP).
  - constant `CDC_MIN_SYNC_STAGES` = 2.
- One sub-module, `bit_synchronizer` (parameter STAGES, async active-low reset to 0), instantiated for the ack path.
- Elaboration check: SYNC_STAGES ≥ `CDC_MIN_SYNC_STAGES`.

## Test plan
- Single pulse, receiver model with a 3-edge delay and SYNC_STAGES=2:
  - req high in cycles 1–6.
  - `o_done` in cycle 13.
  - pending stays 0 throughout.
- Three pulses in cycles 0, 1, 2:
  - pending reads 1 then 2, then drains.
  - req rising edges in cycles 1, 14, 27.
  - three `o_done` strobes.
- PEND_W=2 with ack stuck low:
  - 5 pulses leave pending at 3 plus one event in flight.
  - the 5th pulse gives exactly one `o_overflow` strobe.
- Pulse coinciding with the launch cycle of a pending event: count unchanged at that edge, total delivered events equal total pulses.
- Reset asserted in cycle 8, mid-DROP:
  - all outputs 0 immediately.
  - after release, a new pulse launches normally once `ack_sync` is 0.
- `PULSE_TX_TIMEOUT_EN`, TIMEOUT_CYC=64, ack stuck low:
  - req high in cycles 1–64.
  - `o_timeout`=1 and req=0 in cycle 65.
  - pending cleared, no `o_done`.
